// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor
// Passive performance monitor that sits beside the CMU. It watches the request
// stream (req_valid/req_write) and the CMU stall output, then classifies each
// completed access as a read hit, a write hit or a miss. It accumulates cycle,
// stall and miss-latency statistics.
//
// Parameters
//   CNT_W     width of every event counter
//   LAT_W     width of the per-miss latency counter and max_lat
//   SATURATE  1: counters stick at all-ones, 0: counters wrap to zero
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   clr                       synchronous clear of counters and FSM
//   cnt_en                    0 freezes counters, latency and FSM
//   req_valid, req_write      observed access (write = 1, read = 0)
//   stall                     CMU stall; access completes on req_valid & ~stall
//   req_done, req_hit         one-cycle pulse per completed access, hit/miss flag
//   cyc_cnt .. stall_cnt      event counters (CNT_W)
//   max_lat                   longest stall run of any completed miss (LAT_W)
//
// Optional feature: define CACHE_PERF_SNAPSHOT_EN to add input snap and the
// outputs snap_inst, snap_miss and snap_stall. These shadow registers capture the
// live inst/miss/stall counters on snap. rst clears the shadow registers; clr does not.
module cache_perf_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LAT_W    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic             stall,
`ifdef CACHE_PERF_SNAPSHOT_EN
  input  logic             snap,
  output logic [CNT_W-1:0] snap_inst,
  output logic [CNT_W-1:0] snap_miss,
  output logic [CNT_W-1:0] snap_stall,
`endif
  output logic             req_done,
  output logic             req_hit,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] rd_hit_cnt,
  output logic [CNT_W-1:0] wr_hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [LAT_W-1:0] max_lat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t           r_state, w_state_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt;
  logic [LAT_W-1:0] r_max_lat, w_max_lat_nxt;
  logic [CNT_W-1:0] r_cyc, w_cyc_nxt;
  logic [CNT_W-1:0] r_inst, w_inst_nxt;
  logic [CNT_W-1:0] r_rd_hit, w_rd_hit_nxt;
  logic [CNT_W-1:0] r_wr_hit, w_wr_hit_nxt;
  logic [CNT_W-1:0] r_miss, w_miss_nxt;
  logic [CNT_W-1:0] r_stall, w_stall_nxt;
  logic             r_done, w_done_nxt;
  logic             r_hit, w_hit_nxt;

  // Counter increment honouring the overflow mode.
  function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
    if (SATURATE && (v == CNT_MAX)) return v;
    return v + CNT_W'(1);
  endfunction

  // Next-state, counter updates and completion flags.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat;
    w_max_lat_nxt = r_max_lat;
    w_cyc_nxt     = r_cyc;
    w_inst_nxt    = r_inst;
    w_rd_hit_nxt  = r_rd_hit;
    w_wr_hit_nxt  = r_wr_hit;
    w_miss_nxt    = r_miss;
    w_stall_nxt   = r_stall;
    w_done_nxt    = 1'b0;
    w_hit_nxt     = 1'b0;

    if (cnt_en && req_valid) begin
      w_cyc_nxt = f_inc(r_cyc);
      if (stall) w_stall_nxt = f_inc(r_stall);

      unique case (r_state)
        S_IDLE: begin
          if (stall) begin
            w_state_nxt = S_MISS;
            w_lat_nxt   = LAT_W'(1);
          end else begin
            w_done_nxt = 1'b1;
            w_hit_nxt  = 1'b1;
            w_inst_nxt = f_inc(r_inst);
            if (req_write) w_wr_hit_nxt = f_inc(r_wr_hit);
            else           w_rd_hit_nxt = f_inc(r_rd_hit);
          end
        end
        S_MISS: begin
          if (stall) begin
            // The latency counter always saturates, independent of SATURATE.
            if (r_lat != LAT_MAX) w_lat_nxt = r_lat + LAT_W'(1);
          end else begin
            w_done_nxt    = 1'b1;
            w_inst_nxt    = f_inc(r_inst);
            w_miss_nxt    = f_inc(r_miss);
            w_max_lat_nxt = (r_lat > r_max_lat) ? r_lat : r_max_lat;
            w_state_nxt   = S_IDLE;
            w_lat_nxt     = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (cnt_en && (r_state == S_MISS)) begin
      // Requester withdrew mid-miss: drop the access without counting it.
      w_state_nxt = S_IDLE;
      w_lat_nxt   = '0;
    end
  end

  // State and counter registers; rst and clr both return to the idle/zero state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state   <= S_IDLE;
      r_lat     <= '0;
      r_max_lat <= '0;
      r_cyc     <= '0;
      r_inst    <= '0;
      r_rd_hit  <= '0;
      r_wr_hit  <= '0;
      r_miss    <= '0;
      r_stall   <= '0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat     <= w_lat_nxt;
      r_max_lat <= w_max_lat_nxt;
      r_cyc     <= w_cyc_nxt;
      r_inst    <= w_inst_nxt;
      r_rd_hit  <= w_rd_hit_nxt;
      r_wr_hit  <= w_wr_hit_nxt;
      r_miss    <= w_miss_nxt;
      r_stall   <= w_stall_nxt;
      r_done    <= w_done_nxt;
      r_hit     <= w_hit_nxt;
    end
  end

`ifdef CACHE_PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] r_snap_inst, r_snap_miss, r_snap_stall;

  // Shadow copy of the pre-update live counters; clr leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_inst  <= '0;
      r_snap_miss  <= '0;
      r_snap_stall <= '0;
    end else if (snap) begin
      r_snap_inst  <= r_inst;
      r_snap_miss  <= r_miss;
      r_snap_stall <= r_stall;
    end
  end

  assign snap_inst  = r_snap_inst;
  assign snap_miss  = r_snap_miss;
  assign snap_stall = r_snap_stall;
`endif

  assign req_done   = r_done;
  assign req_hit    = r_hit;
  assign cyc_cnt    = r_cyc;
  assign inst_cnt   = r_inst;
  assign rd_hit_cnt = r_rd_hit;
  assign wr_hit_cnt = r_wr_hit;
  assign miss_cnt   = r_miss;
  assign stall_cnt  = r_stall;
  assign max_lat    = r_max_lat;

endmodule
